// File: rtl/droute_sched_pkg.sv
// Shared constants and channel state encoding for the data_route switch-control sequencer.
package droute_sched_pkg;

    localparam int unsigned CTRL_W    = 18;
    localparam int unsigned CMD_HDR_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chan_state_e;

endpackage

// File: rtl/droute_sched_chan.sv
// One switch channel: holds a ctrl word for a descriptor's beat count, then clears it and pulses done.
module droute_sched_chan
    import droute_sched_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [CNT_W-1:0]  beats_in,
    input  logic              count_tvalid,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              done,
    output logic              busy,
    output logic              zero_len_c,
    output logic              stray_beat_c
);

    chan_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // ctrl_q is only nonzero in RUN, so it drives the switch directly.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ctrl_d       = ctrl_q;
        zero_len_c   = 1'b0;
        stray_beat_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stray_beat_c = count_tvalid;
                if (start) begin
                    cnt_d = beats_in;
                    if (beats_in == '0) begin
                        state_d    = ST_DONE;
                        ctrl_d     = '0;
                        zero_len_c = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        ctrl_d  = ctrl_in;
                    end
                end
            end
            ST_RUN: begin
                if (count_tvalid) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        ctrl_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                stray_beat_c = count_tvalid;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ctrl_d  = '0;
            end
        endcase
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    assign ctrl_out = ctrl_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: rtl/droute_sched.sv
// Command FIFO plus in-order dispatcher feeding the two data_route switch ctrl channels.
module droute_sched
    import droute_sched_pkg::*;
#(
    parameter  int unsigned CNT_W      = 16,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CMD_W      = CMD_HDR_W + CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMD_W-1:0]  s_cmd_tdata,
    input  logic              s_cmd_tvalid,
    output logic              s_cmd_tready,
    output logic [CTRL_W-1:0] m_droute_switch_0,
    input  logic              count_switch_0_tvalid,
    output logic [CTRL_W-1:0] m_droute_switch_1,
    input  logic              count_switch_1_tvalid,
    output logic [1:0]        done,
    output logic [1:0]        busy,
    output logic              err_zero_len,
    output logic              err_stray_beat
);

    localparam int unsigned IDX_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W        = IDX_W + 1;
    localparam int unsigned CMD_BARRIER  = CMD_W - 1;
    localparam int unsigned CMD_SEL      = CMD_W - 2;
    localparam int unsigned CMD_CTRL_MSB = CMD_W - 3;
    localparam int unsigned CMD_CTRL_LSB = CNT_W;

    logic [CMD_W-1:0]  mem_q [FIFO_DEPTH];
    logic [CMD_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              err_zero_len_q, err_zero_len_d;
    logic              err_stray_beat_q, err_stray_beat_d;

    logic              fifo_empty_c;
    logic              fifo_full_c;
    logic              push_c;
    logic              pop_c;
    logic [CMD_W-1:0]  head_cmd_c;
    logic              head_barrier_c;
    logic              head_sel_c;
    logic [CTRL_W-1:0] head_ctrl_c;
    logic [CNT_W-1:0]  head_beats_c;

    logic [1:0]        chan_start_c;
    logic [1:0]        chan_count;
    logic [1:0]        chan_done;
    logic [1:0]        chan_busy;
    logic [1:0]        chan_zero_c;
    logic [1:0]        chan_stray_c;
    logic [CTRL_W-1:0] chan_ctrl [2];

    // Extra pointer bit distinguishes full from empty when indices match.
    assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_c  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                          (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign s_cmd_tready = !fifo_full_c;
    assign push_c       = s_cmd_tvalid && !fifo_full_c;

    assign head_cmd_c     = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign head_barrier_c = head_cmd_c[CMD_BARRIER];
    assign head_sel_c     = head_cmd_c[CMD_SEL];
    assign head_ctrl_c    = head_cmd_c[CMD_CTRL_MSB:CMD_CTRL_LSB];
    assign head_beats_c   = head_cmd_c[CNT_W-1:0];

    // Strict in-order dispatch: a blocked head stalls every later command.
    assign pop_c = !fifo_empty_c && !chan_busy[head_sel_c] &&
                   (!head_barrier_c || (chan_busy == 2'b00));
    assign chan_start_c = {pop_c && head_sel_c, pop_c && !head_sel_c};
    assign chan_count   = {count_switch_1_tvalid, count_switch_0_tvalid};

    always_comb begin
        mem_d            = mem_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        err_zero_len_d   = err_zero_len_q | (|chan_zero_c);
        err_stray_beat_d = err_stray_beat_q | (|chan_stray_c);
        if (push_c) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = s_cmd_tdata;
            wr_ptr_d                   = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            err_zero_len_q   <= 1'b0;
            err_stray_beat_q <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            err_zero_len_q   <= err_zero_len_d;
            err_stray_beat_q <= err_stray_beat_d;
        end
    end

    // Payload storage needs no reset; validity is carried by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar n = 0; n < 2; n++) begin : g_chan
        droute_sched_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .start        (chan_start_c[n]),
            .ctrl_in      (head_ctrl_c),
            .beats_in     (head_beats_c),
            .count_tvalid (chan_count[n]),
            .ctrl_out     (chan_ctrl[n]),
            .done         (chan_done[n]),
            .busy         (chan_busy[n]),
            .zero_len_c   (chan_zero_c[n]),
            .stray_beat_c (chan_stray_c[n])
        );
    end

    assign m_droute_switch_0 = chan_ctrl[0];
    assign m_droute_switch_1 = chan_ctrl[1];
    assign done              = chan_done;
    assign busy              = chan_busy;
    assign err_zero_len      = err_zero_len_q;
    assign err_stray_beat    = err_stray_beat_q;

endmodule

// File: tb/tb_droute_sched.sv
// Bench for droute_sched: fixed vector table, corner-case sequences and random traffic vs a queue model.
module tb_droute_sched;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CMD_W = 36;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CMD_W-1:0] s_cmd_tdata = '0;
    logic             s_cmd_tvalid = 1'b0;
    logic             s_cmd_tready;
    logic [17:0]      sw0, sw1;
    logic             cnt0 = 1'b0, cnt1 = 1'b0;
    logic [1:0]       done, busy;
    logic             ez, es;

    int checks = 0;
    int errors = 0;
    string cur_tag = "init";

    always #5 clk = ~clk;

    droute_sched #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .s_cmd_tdata           (s_cmd_tdata),
        .s_cmd_tvalid          (s_cmd_tvalid),
        .s_cmd_tready          (s_cmd_tready),
        .m_droute_switch_0     (sw0),
        .count_switch_0_tvalid (cnt0),
        .m_droute_switch_1     (sw1),
        .count_switch_1_tvalid (cnt1),
        .done                  (done),
        .busy                  (busy),
        .err_zero_len          (ez),
        .err_stray_beat        (es)
    );

    // Reference model: queue of pending commands, per-switch mode 0=idle 1=running 2=finishing.
    typedef struct {
        logic        bar;
        logic        sel;
        logic [17:0] ctrl;
        int          beats;
    } mcmd_t;

    mcmd_t       mq[$];
    int          m_mode[2];
    int          m_rem[2];
    logic [17:0] m_ctrl[2];
    logic        m_ez, m_es;

    function automatic logic [CMD_W-1:0] mk(input logic bar, input logic sel,
                                            input logic [17:0] ctrl, input int beats);
        return {bar, sel, ctrl, 16'(beats)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int n = 0; n < 2; n++) begin
            m_mode[n] = 0;
            m_rem[n]  = 0;
            m_ctrl[n] = '0;
        end
        m_ez = 1'b0;
        m_es = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [CMD_W-1:0] d, input logic c0, input logic c1);
        mcmd_t h, c;
        bit    pop, push;
        logic  cnt;
        push = v && (mq.size() < int'(DEPTH));
        pop  = 1'b0;
        if (mq.size() > 0) begin
            h = mq[0];
            if (m_mode[int'(h.sel)] == 0 && (!h.bar || (m_mode[0] == 0 && m_mode[1] == 0)))
                pop = 1'b1;
        end
        for (int n = 0; n < 2; n++) begin
            cnt = (n == 0) ? c0 : c1;
            case (m_mode[n])
                0: begin
                    if (cnt) m_es = 1'b1;
                    if (pop && int'(h.sel) == n) begin
                        if (h.beats == 0) begin
                            m_mode[n] = 2;
                            m_ez      = 1'b1;
                        end else begin
                            m_mode[n] = 1;
                            m_rem[n]  = h.beats;
                            m_ctrl[n] = h.ctrl;
                        end
                    end
                end
                1: if (cnt) begin
                    m_rem[n]--;
                    if (m_rem[n] == 0) m_mode[n] = 2;
                end
                default: begin
                    if (cnt) m_es = 1'b1;
                    m_mode[n] = 0;
                end
            endcase
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            c.bar   = d[35];
            c.sel   = d[34];
            c.ctrl  = d[33:16];
            c.beats = int'(d[15:0]);
            mq.push_back(c);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sw0"},   32'(sw0), 32'((m_mode[0] == 1) ? m_ctrl[0] : 18'h0));
        chk({tag, ".sw1"},   32'(sw1), 32'((m_mode[1] == 1) ? m_ctrl[1] : 18'h0));
        chk({tag, ".done"},  32'(done), 32'({m_mode[1] == 2, m_mode[0] == 2}));
        chk({tag, ".busy"},  32'(busy), 32'({m_mode[1] != 0, m_mode[0] != 0}));
        chk({tag, ".ezl"},   32'(ez), 32'(m_ez));
        chk({tag, ".estr"},  32'(es), 32'(m_es));
        chk({tag, ".ready"}, 32'(s_cmd_tready), 32'(mq.size() < int'(DEPTH)));
    endtask

    task automatic step(input logic v, input logic [CMD_W-1:0] d, input logic c0, input logic c1);
        s_cmd_tvalid = v;
        s_cmd_tdata  = d;
        cnt0         = c0;
        cnt1         = c1;
        @(posedge clk);
        model_step(v, d, c0, c1);
        #1;
        check_all(cur_tag);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        s_cmd_tvalid = 1'b0;
        cnt0         = 1'b0;
        cnt1         = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        check_all("reset");
    endtask

    // Fixed vectors: inputs for one cycle and outputs expected just after that edge.
    typedef struct {
        logic             v;
        logic [CMD_W-1:0] d;
        logic             c0, c1;
        logic [17:0]      e0, e1;
        logic [1:0]       ed, eb;
        logic             ez, es, er;
    } vec_t;

    vec_t tv[10];

    function automatic vec_t mkv(input logic v, input logic [CMD_W-1:0] d, input logic c0, input logic c1,
                                 input logic [17:0] e0, input logic [17:0] e1, input logic [1:0] ed,
                                 input logic [1:0] eb, input logic ezv, input logic esv, input logic er);
        vec_t r;
        r.v = v; r.d = d; r.c0 = c0; r.c1 = c1; r.e0 = e0; r.e1 = e1;
        r.ed = ed; r.eb = eb; r.ez = ezv; r.es = esv; r.er = er;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0, d1, first_done0, first_sw1, first_idle0, ready_at;
        logic [17:0] prev_sw0;
        bit bad_gap, seen_b;
        logic [CMD_W-1:0] fifth;
        int prob;

        tv[0] = mkv(1, mk(0, 0, 18'h00249, 3),     0, 0, 18'h0,     0, 2'b00, 2'b00, 0, 0, 1);
        tv[1] = mkv(0, '0,                         0, 0, 18'h00249, 0, 2'b00, 2'b01, 0, 0, 1);
        tv[2] = mkv(0, '0,                         1, 0, 18'h00249, 0, 2'b00, 2'b01, 0, 0, 1);
        tv[3] = mkv(0, '0,                         1, 0, 18'h00249, 0, 2'b00, 2'b01, 0, 0, 1);
        tv[4] = mkv(0, '0,                         1, 0, 18'h0,     0, 2'b01, 2'b01, 0, 0, 1);
        tv[5] = mkv(0, '0,                         0, 0, 18'h0,     0, 2'b00, 2'b00, 0, 0, 1);
        tv[6] = mkv(1, mk(0, 1, 18'h3FFFF, 0),     0, 0, 18'h0,     0, 2'b00, 2'b00, 0, 0, 1);
        tv[7] = mkv(0, '0,                         0, 0, 18'h0,     0, 2'b10, 2'b10, 1, 0, 1);
        tv[8] = mkv(0, '0,                         0, 0, 18'h0,     0, 2'b00, 2'b00, 1, 0, 1);
        tv[9] = mkv(0, '0,                         0, 1, 18'h0,     0, 2'b00, 2'b00, 1, 1, 1);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            s_cmd_tvalid = tv[i].v;
            s_cmd_tdata  = tv[i].d;
            cnt0         = tv[i].c0;
            cnt1         = tv[i].c1;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.sw0", i),   32'(sw0), 32'(tv[i].e0));
            chk($sformatf("vec%0d.sw1", i),   32'(sw1), 32'(tv[i].e1));
            chk($sformatf("vec%0d.done", i),  32'(done), 32'(tv[i].ed));
            chk($sformatf("vec%0d.busy", i),  32'(busy), 32'(tv[i].eb));
            chk($sformatf("vec%0d.ezl", i),   32'(ez), 32'(tv[i].ez));
            chk($sformatf("vec%0d.estr", i),  32'(es), 32'(tv[i].es));
            chk($sformatf("vec%0d.ready", i), 32'(s_cmd_tready), 32'(tv[i].er));
        end

        // Two switches running concurrently; 4 vs 2 beats with pulses every running cycle.
        do_reset();
        cur_tag = "conc";
        step(1, mk(0, 0, 18'h00111, 4), 0, 0);
        step(1, mk(0, 1, 18'h00222, 2), 0, 0);
        step(0, '0, 0, 0);
        chk("conc_busy", 32'(busy), 32'(2'b11));
        d0 = -1; d1 = -1;
        for (int i = 0; i < 10; i++) begin
            step(0, '0, m_mode[0] == 1, m_mode[1] == 1);
            if (done[0] && d0 < 0) d0 = i;
            if (done[1] && d1 < 0) d1 = i;
        end
        chk("conc_d1", 32'(d1), 32'(1));
        chk("conc_gap", 32'(d0 - d1), 32'(2));

        // Head-of-line blocking behind a busy switch 0.
        do_reset();
        cur_tag = "hol";
        step(1, mk(0, 0, 18'h00AAA, 5), 0, 0);
        step(1, mk(0, 0, 18'h00BBB, 1), 0, 0);
        step(1, mk(0, 1, 18'h00CCC, 1), 0, 0);
        first_done0 = -1; first_sw1 = -1; bad_gap = 0; seen_b = 0;
        prev_sw0 = sw0;
        for (int i = 0; i < 20; i++) begin
            step(0, '0, m_mode[0] == 1, m_mode[1] == 1);
            if (done[0] && first_done0 < 0) first_done0 = i;
            if (sw1 != 0 && first_sw1 < 0) first_sw1 = i;
            if (prev_sw0 == 18'h00AAA && sw0 == 18'h00BBB) bad_gap = 1;
            if (sw0 == 18'h00BBB) seen_b = 1;
            prev_sw0 = sw0;
        end
        chk("hol_order", 32'(first_done0 >= 0 && first_sw1 > first_done0), 32'(1));
        chk("hol_gap", 32'(bad_gap), 32'(0));
        chk("hol_second", 32'(seen_b), 32'(1));

        // Barrier command waits for both switches idle.
        do_reset();
        cur_tag = "bar";
        step(1, mk(0, 0, 18'h00DDD, 2), 0, 0);
        step(1, mk(1, 1, 18'h00EEE, 1), 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 0);
            chk("bar_hold", 32'(sw1), 32'(0));
        end
        first_idle0 = -1; first_sw1 = -1;
        for (int i = 0; i < 10; i++) begin
            step(0, '0, m_mode[0] == 1, m_mode[1] == 1);
            if (!busy[0] && first_idle0 < 0) first_idle0 = i;
            if (sw1 != 0 && first_sw1 < 0) first_sw1 = i;
        end
        chk("bar_idle0", 32'(first_idle0), 32'(2));
        chk("bar_load", 32'(first_sw1 - first_idle0), 32'(1));

        // FIFO full while switch 0 is busy, released by a pop.
        do_reset();
        cur_tag = "full";
        step(1, mk(0, 0, 18'h00123, 3), 0, 0);
        step(0, '0, 0, 0);
        for (int k = 0; k < 4; k++) step(1, mk(0, 0, 18'h00200 + 18'(k), 1), 0, 0);
        chk("full_ready", 32'(s_cmd_tready), 32'(0));
        fifth = mk(0, 0, 18'h00300, 1);
        ready_at = -1;
        for (int i = 0; i < 20 && ready_at < 0; i++) begin
            step(1, fifth, m_mode[0] == 1, 0);
            if (s_cmd_tready) ready_at = i;
        end
        chk("full_release", 32'(ready_at), 32'(4));
        step(1, fifth, m_mode[0] == 1, 0);
        for (int i = 0; i < 30; i++) step(0, '0, m_mode[0] == 1, 0);
        chk("full_drain", 32'(busy), 32'(0));

        // Reset in the middle of a run with 7 beats left and a command queued.
        do_reset();
        cur_tag = "rstrun";
        step(1, mk(0, 0, 18'h30F0F, 10), 0, 0);
        step(1, mk(1, 1, 18'h12345, 3), 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
        chk("rstrun_pre", 32'(sw0), 32'(18'h30F0F));
        do_reset();
        chk("rstrun_sw0", 32'(sw0), 32'(0));
        chk("rstrun_busy", 32'(busy), 32'(0));
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0);
        chk("rstrun_flushed", 32'(sw1), 32'(0));
        step(0, '0, 1, 0);
        chk("rstrun_stray", 32'(es), 32'(1));

        // Random traffic at increasing pulse density.
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            cur_tag = $sformatf("rnd%0d", seg);
            prob = 30 + seg * 25;
            for (int i = 0; i < 400; i++) begin
                step($urandom_range(0, 2) == 0,
                     mk($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                        18'($urandom), int'($urandom_range(0, 6))),
                     $urandom_range(0, 99) < prob,
                     $urandom_range(0, 99) < prob);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
